adc_frame_packer: RTL and testbench
===================================

# adc_frame_packer

Parametrised multi-channel ADC capture stage for the 16-channel receiver. It accepts per-channel sample strobes from the LTC2203 front-end, already retimed into the system clock domain. Each channel is decimated by a runtime power-of-two boxcar average. One result per channel is gathered into a frame, and the frame is serialised over a valid/ready stream tagged with channel index and frame markers for the downstream buffer/DMA.

## Interface
- CH_NUM, 16: number of ADC channels (2..32)
- DW, 16: sample width, two's complement after format conversion
- MAX_SHIFT, 8: maximum decimation shift; accumulator width DW+MAX_SHIFT
- CHW, $clog2(CH_NUM): channel index width (localparam)
- SW, $clog2(MAX_SHIFT+1): DEC_SHIFT width (localparam)

Ports:
- CLK  in  1  system clock; sole clock
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  capture enable
- DEC_SHIFT  in  SW  decimation D = 2^DEC_SHIFT; values > MAX_SHIFT clamp to MAX_SHIFT
- IN_VALID  in  CH_NUM  per-channel sample strobe, one CLK wide
- IN_DATA  in  CH_NUM*DW  channel i at [i*DW +: DW]
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  downstream accept
- OUT_DATA  out  DW  decimated sample
- OUT_CH  out  CHW  channel index of beat
- OUT_SOF  out  1  high on channel-0 beat
- OUT_EOF  out  1  high on channel CH_NUM-1 beat
- OVERFLOW  out  1  sticky: a channel result was overwritten before capture
- FRAME_CNT  out  32  frames fully transmitted, wraps 0xFFFFFFFF -> 0

## Operation
- Per channel:
  - Accumulator ACC (DW+MAX_SHIFT, signed), sample counter CNT, result register RES (DW), flag RDY.
  - On IN_VALID[i] with EN=1, ACC += sign-extended sample and CNT increments.
  - When CNT reaches D-1 on a valid sample:
    - RES = (ACC+sample) >>> DEC_SHIFT (arithmetic shift, floor toward -inf).
    - ACC and CNT clear; RDY sets.
  - D=1 passes samples through.
- If RDY[i] is already set when a new result completes, RES is overwritten and OVERFLOW sets. OVERFLOW clears only on RESET.
- Frame capture happens when all RDY are set and the serialiser is IDLE:
  - All RES copy to the shadow frame.
  - All RDY clear in the same edge.
  - A result completing on that same edge sets RDY for the next frame; it does not count as overflow.
- Serialiser FSM:
  - IDLE: on capture, go to SEND with index 0.
  - SEND: OUT_VALID=1 and OUT_CH=index. On OUT_VALID&OUT_READY:
    - If index = CH_NUM-1, go to IDLE and increment FRAME_CNT.
    - Otherwise, increment index.
- While the serialiser is busy, RDY flags hold and capture waits. Overflow can occur during this wait.
- EN=0:
  - Accumulators, counters, RDY and RES clear.
  - A frame already in SEND completes normally.
  - DEC_SHIFT changes take effect cleanly only across an EN=0 period. A change while EN=1 gives an undefined first result per channel.
- RESET: all state clears asynchronously; FSM returns to IDLE.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_CH=0, OUT_SOF=0, OUT_EOF=0, OVERFLOW=0, FRAME_CNT=0.
- IN_VALID sampled at edge k sets RDY at edge k. Capture occurs at edge k+1. OUT_VALID is high after edge k+1: 2-cycle latency from the completing sample.
- With OUT_READY held high: one beat per CLK, and a frame takes CH_NUM cycles.
- After the EOF handshake there is one IDLE cycle minimum before the next SOF.
- OUT_DATA, OUT_CH, OUT_SOF and OUT_EOF are registered. They hold stable while OUT_VALID=1 and OUT_READY=0.
- OUT_VALID does not drop without a handshake, except on RESET.

## Configuration
- ADC_OFFSET_BIN_EN defined:
  - Each IN_DATA word is offset binary and is converted by inverting its MSB before accumulation.
  - Example: 0x8000 -> 0x0000.
- Not defined:
  - IN_DATA is taken as two's complement unchanged.

## Test plan
- Basic pass-through:
  - Stimulus: CH_NUM=4, DEC_SHIFT=0, all IN_VALID together, ch i data = 0x0101*(i+1), OUT_READY=1.
  - Response: 4 consecutive beats, OUT_CH 0..3, data 0x0101/0x0202/0x0303/0x0404, SOF on beat 0, EOF on beat 3, FRAME_CNT=1, first OUT_VALID 2 cycles after the input strobe.
- Decimation averaging:
  - Stimulus: DEC_SHIFT=2, ch0 fed 4, 8, 0xFFFC, 0.
  - Response: ch0 result 0x0002.
  - Stimulus: ch0 fed 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC.
  - Response: ch0 result 0xFFFD (floor of -2.5). No result before the 4th sample.
- Backpressure:
  - Stimulus: OUT_READY low for 5 cycles after the beat-1 handshake.
  - Response: OUT_VALID stays 1; OUT_CH=2 and OUT_DATA are stable throughout; all 4 beats are delivered in order with none lost or duplicated.
- Overflow:
  - Stimulus: OUT_READY=0, DEC_SHIFT=0, three IN_VALID rounds.
  - Response: frame 1 is held in SEND; round 2 sets RDY with OVERFLOW=0; round 3 sets OVERFLOW=1.
  - Then raise OUT_READY: frame 1 is delivered, then frame 2 carrying round-3 data; OVERFLOW stays 1.
- Reset mid-frame:
  - Stimulus: assert RESET after the beat-1 handshake.
  - Response: OUT_VALID=0 immediately (asynchronous), FRAME_CNT=0.
  - The next frame starts at OUT_CH=0 with SOF, and partial accumulations are discarded.
- Format macro:
  - With ADC_OFFSET_BIN_EN and DEC_SHIFT=0: inputs 0x8000 and 0x0000 give outputs 0x0000 and 0x8000.
  - Without the macro: inputs pass through unchanged.

Source files
------------

// File: rtl/adc_frame_packer.sv
// Multi-channel ADC decimator and frame serialiser with valid/ready output.
// Optional ADC_OFFSET_BIN_EN: input words are offset binary (MSB inverted before use).
module adc_frame_packer #(
  parameter  int CH_NUM    = 16,
  parameter  int DW        = 16,
  parameter  int MAX_SHIFT = 8,
  localparam int CHW       = $clog2(CH_NUM),
  localparam int SW        = $clog2(MAX_SHIFT + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic [SW-1:0]        DEC_SHIFT,
  input  logic [CH_NUM-1:0]    IN_VALID,
  input  logic [CH_NUM*DW-1:0] IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DW-1:0]        OUT_DATA,
  output logic [CHW-1:0]       OUT_CH,
  output logic                 OUT_SOF,
  output logic                 OUT_EOF,
  output logic                 OVERFLOW,
  output logic [31:0]          FRAME_CNT
);

  localparam int AW = DW + MAX_SHIFT;
  localparam int CW = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic signed [AW-1:0] r_acc   [CH_NUM];
  logic [CW-1:0]        r_cnt   [CH_NUM];
  logic [DW-1:0]        r_res   [CH_NUM];
  logic [DW-1:0]        r_frame [CH_NUM];
  logic [CH_NUM-1:0]    r_rdy;
  logic                 r_ovf;

  logic [0:0]           r_state;
  logic [CHW-1:0]       r_idx;
  logic [DW-1:0]        r_out_data;
  logic [CHW-1:0]       r_out_ch;
  logic                 r_sof;
  logic                 r_eof;
  logic [31:0]          r_frame_cnt;

  logic [SW-1:0]        w_shift;
  logic [CW-1:0]        w_dm1;
  logic [DW-1:0]        w_conv [CH_NUM];
  logic signed [AW-1:0] w_sum  [CH_NUM];
  logic [CH_NUM-1:0]    w_done;
  logic                 w_capture;
  logic                 w_hs;
  logic [CHW-1:0]       w_nxt;

  assign w_shift = (DEC_SHIFT > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : DEC_SHIFT;

  // Terminal count D-1 = 2^shift - 1 as a low-order run of ones
  always_comb begin
    w_dm1 = '0;
    for (int j = 0; j < CW; j++) begin
      w_dm1[j] = (j < int'(w_shift));
    end
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
`ifdef ADC_OFFSET_BIN_EN
      w_conv[i] = {~IN_DATA[i*DW + DW - 1], IN_DATA[i*DW +: DW-1]};
`else
      w_conv[i] = IN_DATA[i*DW +: DW];
`endif
      w_sum[i]  = r_acc[i] + {{MAX_SHIFT{w_conv[i][DW-1]}}, w_conv[i]};
      w_done[i] = IN_VALID[i] && (r_cnt[i] == w_dm1);
    end
  end

  assign w_capture = EN && (&r_rdy) && (r_state == ST_IDLE);
  assign w_hs      = (r_state == ST_SEND) && OUT_READY;
  assign w_nxt     = r_idx + CHW'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
        r_res[i] <= '0;
      end
      r_rdy <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!EN) begin
          r_acc[i] <= '0;
          r_cnt[i] <= '0;
          r_res[i] <= '0;
          r_rdy[i] <= 1'b0;
        end else begin
          if (w_done[i]) begin
            r_res[i] <= DW'(w_sum[i] >>> w_shift);
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
          end else if (IN_VALID[i]) begin
            r_acc[i] <= w_sum[i];
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
          // A result landing on the capture edge belongs to the next frame
          if (w_done[i]) r_rdy[i] <= 1'b1;
          else if (w_capture) r_rdy[i] <= 1'b0;
        end
      end
      if (EN && |(w_done & r_rdy & ~{CH_NUM{w_capture}})) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CH_NUM; i++) r_frame[i] <= '0;
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            for (int i = 0; i < CH_NUM; i++) r_frame[i] <= r_res[i];
            r_state    <= ST_SEND;
            r_idx      <= '0;
            r_out_data <= r_res[0];
            r_out_ch   <= '0;
            r_sof      <= 1'b1;
            r_eof      <= 1'b0;
          end
        end
        default: begin
          if (w_hs) begin
            if (r_idx == CHW'(CH_NUM - 1)) begin
              r_state     <= ST_IDLE;
              r_frame_cnt <= r_frame_cnt + 32'd1;
            end else begin
              r_idx      <= w_nxt;
              r_out_data <= r_frame[w_nxt];
              r_out_ch   <= w_nxt;
              r_sof      <= 1'b0;
              r_eof      <= (w_nxt == CHW'(CH_NUM - 1));
            end
          end
        end
      endcase
    end
  end

  assign OUT_VALID = (r_state == ST_SEND);
  assign OUT_DATA  = r_out_data;
  assign OUT_CH    = r_out_ch;
  assign OUT_SOF   = r_sof;
  assign OUT_EOF   = r_eof;
  assign OVERFLOW  = r_ovf;
  assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed self-checking bench for adc_frame_packer with 4 channels.
module tb_adc_frame_packer;

  logic        CLK = 1'b0;
  logic        RESET, EN, OUT_READY;
  logic [3:0]  DEC_SHIFT;
  logic [3:0]  IN_VALID;
  logic [63:0] IN_DATA;
  logic        OUT_VALID, OUT_SOF, OUT_EOF, OVERFLOW;
  logic [15:0] OUT_DATA;
  logic [1:0]  OUT_CH;
  logic [31:0] FRAME_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  logic [15:0] q_data[$];
  logic [1:0]  q_ch[$];
  logic        q_sof[$];
  logic        q_eof[$];

  adc_frame_packer #(.CH_NUM(4), .DW(16), .MAX_SHIFT(8)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DEC_SHIFT(DEC_SHIFT),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_CH(OUT_CH), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF),
    .OVERFLOW(OVERFLOW), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RESET && OUT_VALID && OUT_READY) begin
      q_data.push_back(OUT_DATA);
      q_ch.push_back(OUT_CH);
      q_sof.push_back(OUT_SOF);
      q_eof.push_back(OUT_EOF);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input logic [3:0] m, input logic [15:0] d0, d1, d2, d3);
    IN_VALID = m;
    IN_DATA  = {d3, d2, d1, d0};
    tick();
    IN_VALID = '0;
  endtask

  task automatic en_cycle(input logic [3:0] sh);
    EN = 1'b0;
    tick();
    DEC_SHIFT = sh;
    EN = 1'b1;
  endtask

  task automatic clear_q();
    q_data.delete(); q_ch.delete(); q_sof.delete(); q_eof.delete();
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 60 && FRAME_CNT != target; i++) tick();
    check("frame_cnt", FRAME_CNT, target);
  endtask

  task automatic wait_beat1();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (OUT_VALID && OUT_CH == 2'd1) found = 1'b1;
      else tick();
    end
    check("wait_beat1", found, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [15:0] e [4]);
    if (q_data.size() < base + 4) begin
      check({tag, "_short"}, q_data.size(), base + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_ch"},   q_ch[base+i], i);
        check({tag, "_data"}, q_data[base+i], e[i]);
        check({tag, "_sof"},  q_sof[base+i], (i == 0));
        check({tag, "_eof"},  q_eof[base+i], (i == 3));
      end
    end
  endtask

  initial begin
    logic [15:0] e [4];
    RESET = 1'b1; EN = 1'b0; OUT_READY = 1'b0; DEC_SHIFT = '0;
    IN_VALID = '0; IN_DATA = '0;
    repeat (3) tick();
    check("rst_valid", OUT_VALID, 0);
    check("rst_data", OUT_DATA, 0);
    check("rst_ch", OUT_CH, 0);
    check("rst_sof", OUT_SOF, 0);
    check("rst_eof", OUT_EOF, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_fcnt", FRAME_CNT, 0);
    RESET = 1'b0;
    tick();

    // Pass-through and latency
    EN = 1'b1; OUT_READY = 1'b1;
    tick();
    sample(4'hF, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    check("lat_k", OUT_VALID, 0);
    tick();
    check("lat_k1_valid", OUT_VALID, 1);
    check("lat_k1_ch", OUT_CH, 0);
    check("lat_k1_sof", OUT_SOF, 1);
    exp_frames = 1;
    wait_frames(exp_frames);
    check("pt_beats", q_data.size(), 4);
    e = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    check_frame("pt", 0, e);
    clear_q();

    // Decimation by 4
    en_cycle(4'd2);
    tick();
    sample(4'hF, 16'h0004, 16'h0010, 16'h0001, 16'h0003);
    sample(4'hF, 16'h0008, 16'h0010, 16'h0001, 16'h0003);
    sample(4'hF, 16'hFFFC, 16'h0010, 16'h0001, 16'h0003);
    tick();
    check("dec1_early", OUT_VALID, 0);
    sample(4'hF, 16'h0000, 16'h0010, 16'h0000, 16'h0003);
    exp_frames = 2;
    wait_frames(exp_frames);
    e = '{16'h0002, 16'h0010, 16'h0000, 16'h0003};
    check_frame("dec1", 0, e);
    clear_q();
    sample(4'hF, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000);
    sample(4'hF, 16'hFFFE, 16'h0002, 16'h7FFF, 16'h8000);
    sample(4'hF, 16'hFFFD, 16'h0003, 16'h7FFF, 16'h8000);
    tick();
    check("dec2_early", OUT_VALID, 0);
    sample(4'hF, 16'hFFFC, 16'h0004, 16'h7FFF, 16'h8000);
    exp_frames = 3;
    wait_frames(exp_frames);
    e = '{16'hFFFD, 16'h0002, 16'h7FFF, 16'h8000};
    check_frame("dec2", 0, e);
    clear_q();

    // Backpressure on beat 2
    en_cycle(4'd0);
    tick();
    sample(4'hF, 16'hA001, 16'hB002, 16'hC003, 16'hD004);
    wait_beat1();
    tick();
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", OUT_VALID, 1);
      check("bp_ch", OUT_CH, 2);
      check("bp_data", OUT_DATA, 16'hC003);
      tick();
    end
    OUT_READY = 1'b1;
    exp_frames = 4;
    wait_frames(exp_frames);
    check("bp_beats", q_data.size(), 4);
    e = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    check_frame("bp", 0, e);
    clear_q();

    // Overflow while frame is held
    OUT_READY = 1'b0;
    sample(4'hF, 16'h0011, 16'h0012, 16'h0013, 16'h0014);
    tick();
    check("ovf_r1_valid", OUT_VALID, 1);
    check("ovf_r1", OVERFLOW, 0);
    sample(4'hF, 16'h0021, 16'h0022, 16'h0023, 16'h0024);
    check("ovf_r2", OVERFLOW, 0);
    sample(4'hF, 16'h0031, 16'h0032, 16'h0033, 16'h0034);
    check("ovf_r3", OVERFLOW, 1);
    OUT_READY = 1'b1;
    exp_frames = 6;
    wait_frames(exp_frames);
    check("ovf_beats", q_data.size(), 8);
    e = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};
    check_frame("ovf_f1", 0, e);
    e = '{16'h0031, 16'h0032, 16'h0033, 16'h0034};
    check_frame("ovf_f2", 4, e);
    check("ovf_sticky", OVERFLOW, 1);
    clear_q();

    // Reset mid-frame discards partial accumulation
    en_cycle(4'd1);
    tick();
    sample(4'hF, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    sample(4'hF, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    sample(4'hF, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_beat1();
    tick();
    RESET = 1'b1;
    #1;
    check("rst_mid_valid", OUT_VALID, 0);
    check("rst_mid_fcnt", FRAME_CNT, 0);
    check("rst_mid_ovf", OVERFLOW, 0);
    tick();
    RESET = 1'b0;
    clear_q();
    tick();
    sample(4'hF, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    sample(4'hF, 16'h0030, 16'h0060, 16'h0090, 16'h00C0);
    exp_frames = 1;
    wait_frames(exp_frames);
    check("rst_beats", q_data.size(), 4);
    e = '{16'h0020, 16'h0040, 16'h0060, 16'h0080};
    check_frame("rst_f", 0, e);
    clear_q();

    // Input format
    en_cycle(4'd0);
    tick();
    sample(4'hF, 16'h8000, 16'h0000, 16'h1234, 16'hFFFF);
    exp_frames = 2;
    wait_frames(exp_frames);
`ifdef ADC_OFFSET_BIN_EN
    e = '{16'h0000, 16'h8000, 16'h9234, 16'h7FFF};
`else
    e = '{16'h8000, 16'h0000, 16'h1234, 16'hFFFF};
`endif
    check_frame("fmt", 0, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
